// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: default geometry and the access-controller state encoding.
// Both the memory model and the controller import this so their widths agree.
package dmem_pkg;

  localparam int DATA_W      = 24;
  localparam int ADDR_W      = 24;
  localparam int DEPTH       = 24;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage : dmem_pkg

// File: rtl/dmem_access_ctrl_if.sv
// Request/response handshake plus memory pins between the execute stage, the controller and the memory.
// slave = the controller side, master = the execute stage / memory side.
interface dmem_access_ctrl_if #(
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int ADDR_W = dmem_pkg::ADDR_W
);

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;

  logic              RspValid;
  logic              RspReady;
  logic [DATA_W-1:0] RspRData;
  logic              RspErr;

  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite;
  logic [DATA_W-1:0] MemData;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, MemData,
    output ReqReady, RspValid, RspRData, RspErr, MemAddress, MemWriteData, MemWrite
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, MemData,
    input  ReqReady, RspValid, RspRData, RspErr, MemAddress, MemWriteData, MemWrite
  );

endinterface : dmem_access_ctrl_if

// File: rtl/dmem_access_ctrl.sv
// CPU-side initiator for the data memory: accepts one load/store at a time, holds the
// address for WAIT_CYCLES+1 cycles, samples the combinational read data and returns a response.
//
// state  | meaning
// IDLE   | ready for a request (ReqReady=1)
// ACCESS | address driven to memory; MemWrite only in the first cycle; wait counter running
// RESP   | response held on the Rsp channel until RspReady
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = dmem_pkg::DATA_W,
  parameter int ADDR_W      = dmem_pkg::ADDR_W,
  parameter int DEPTH       = dmem_pkg::DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  dmem_access_ctrl_if.slave   bus
);

  localparam logic [ADDR_W-1:0]     DEPTH_LIM = ADDR_W'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LD   = WAIT_CNT_W'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_write_q, mem_write_d;

  logic                req_ready;
  logic                addr_bad;

  // Full-width unsigned compare so high address bits can never alias into range.
  assign addr_bad  = (bus.ReqAddr >= DEPTH_LIM);
  assign req_ready = (state_q == IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          wr_d        = bus.ReqWrite;
          mem_wdata_d = bus.ReqWData;
          if (addr_bad) begin
            // Error path never touches the memory pins except WriteData.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = WAIT_LD;
            mem_addr_d  = bus.ReqAddr;
            mem_write_d = bus.ReqWrite;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_q ? '0 : bus.MemData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        if (bus.RspReady) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.ReqReady     = req_ready;
  assign bus.RspValid     = rsp_valid_q;
  assign bus.RspRData     = rsp_rdata_q;
  assign bus.RspErr       = rsp_err_q;
  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemWriteData = mem_wdata_q;
  assign bus.MemWrite     = mem_write_q;

endmodule : dmem_access_ctrl

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: WAIT_CYCLES=1 instance against a 24-word memory model,
// plus WAIT_CYCLES=0 and 3 instances against a fixed read pattern for the latency sweep.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic Clk;
  logic Rst_n;

  int errors;
  int checks;

  dmem_access_ctrl_if #(.DATA_W(24), .ADDR_W(24)) ifa ();
  dmem_access_ctrl_if #(.DATA_W(24), .ADDR_W(24)) ifb ();
  dmem_access_ctrl_if #(.DATA_W(24), .ADDR_W(24)) ifc ();

  dmem_access_ctrl #(.DATA_W(24), .ADDR_W(24), .DEPTH(24), .WAIT_CYCLES(1)) u_dut_w1 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifa)
  );
  dmem_access_ctrl #(.DATA_W(24), .ADDR_W(24), .DEPTH(24), .WAIT_CYCLES(0)) u_dut_w0 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifb)
  );
  dmem_access_ctrl #(.DATA_W(24), .ADDR_W(24), .DEPTH(24), .WAIT_CYCLES(3)) u_dut_w3 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory behind the WAIT_CYCLES=1 controller: write on rising edge, combinational read.
  logic [23:0] mem_a [24];
  initial begin
    for (int i = 0; i < 24; i++) mem_a[i] <= 24'hA00000 | 24'(i);
  end
  always @(posedge Clk) begin
    if (ifa.MemWrite && (ifa.MemAddress < 24'd24)) mem_a[ifa.MemAddress[4:0]] <= ifa.MemWriteData;
  end
  assign ifa.MemData = (ifa.MemAddress < 24'd24) ? mem_a[ifa.MemAddress[4:0]] : 24'h0;
  assign ifb.MemData = ifb.MemAddress ^ 24'h5A5A5A;
  assign ifc.MemData = ifc.MemAddress ^ 24'h5A5A5A;

  task automatic issue(input int sel, input logic wr, input logic [23:0] addr, input logic [23:0] data);
    case (sel)
      0: begin ifa.ReqValid = 1'b1; ifa.ReqWrite = wr; ifa.ReqAddr = addr; ifa.ReqWData = data; end
      1: begin ifb.ReqValid = 1'b1; ifb.ReqWrite = wr; ifb.ReqAddr = addr; ifb.ReqWData = data; end
      default: begin ifc.ReqValid = 1'b1; ifc.ReqWrite = wr; ifc.ReqAddr = addr; ifc.ReqWData = data; end
    endcase
    @(posedge Clk);
    #1;
    ifa.ReqValid = 1'b0;
    ifb.ReqValid = 1'b0;
    ifc.ReqValid = 1'b0;
  endtask

  function automatic logic rsp_valid_of(input int sel);
    case (sel)
      0:       return ifa.RspValid;
      1:       return ifb.RspValid;
      default: return ifc.RspValid;
    endcase
  endfunction

  // Returns the number of edges after the accept edge at which RspValid was first seen; 99 on timeout.
  task automatic wait_rsp(input int sel, output int cyc);
    cyc = 0;
    while (!rsp_valid_of(sel) && cyc < 20) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    if (!rsp_valid_of(sel)) cyc = 99;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      ifa.ReqValid = ~ifa.ReqValid;
      ifa.ReqWrite = 1'b1;
      ifa.ReqAddr  = 24'd5;
      ifa.ReqWData = 24'hFFFFFF;
      ifa.RspReady = ~ifa.RspReady;
    end
    #1;
    checks++; if (ifa.ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ReqReady got=%b exp=1", ifa.ReqReady); end
    checks++; if (ifa.RspValid !== 1'b0) begin errors++; $display("FAIL reset_RspValid got=%b exp=0", ifa.RspValid); end
    checks++; if (ifa.RspRData !== 24'h0) begin errors++; $display("FAIL reset_RspRData got=%h exp=0", ifa.RspRData); end
    checks++; if (ifa.RspErr !== 1'b0) begin errors++; $display("FAIL reset_RspErr got=%b exp=0", ifa.RspErr); end
    checks++; if (ifa.MemAddress !== 24'h0) begin errors++; $display("FAIL reset_MemAddress got=%h exp=0", ifa.MemAddress); end
    checks++; if (ifa.MemWriteData !== 24'h0) begin errors++; $display("FAIL reset_MemWriteData got=%h exp=0", ifa.MemWriteData); end
    checks++; if (ifa.MemWrite !== 1'b0) begin errors++; $display("FAIL reset_MemWrite got=%b exp=0", ifa.MemWrite); end
    ifa.ReqValid = 1'b0;
    ifa.RspReady = 1'b1;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      checks++; if (ifa.MemWrite !== 1'b0 || ifa.ReqReady !== 1'b1) begin
        errors++; $display("FAIL post_reset_idle MemWrite=%b ReqReady=%b exp 0/1", ifa.MemWrite, ifa.ReqReady);
      end
    end
  endtask

  task automatic test_store_load;
    int cyc;
    issue(0, 1'b1, 24'd5, 24'hABCDEF);
    checks++; if (ifa.MemWrite !== 1'b1) begin errors++; $display("FAIL store_MemWrite_E0 got=%b exp=1", ifa.MemWrite); end
    checks++; if (ifa.MemAddress !== 24'd5) begin errors++; $display("FAIL store_MemAddress got=%h exp=5", ifa.MemAddress); end
    checks++; if (ifa.MemWriteData !== 24'hABCDEF) begin errors++; $display("FAIL store_MemWriteData got=%h exp=abcdef", ifa.MemWriteData); end
    checks++; if (ifa.ReqReady !== 1'b0) begin errors++; $display("FAIL store_ReqReady_busy got=%b exp=0", ifa.ReqReady); end
    @(posedge Clk);
    #1;
    checks++; if (ifa.MemWrite !== 1'b0) begin errors++; $display("FAIL store_MemWrite_E1 got=%b exp=0", ifa.MemWrite); end
    checks++; if (ifa.RspValid !== 1'b0) begin errors++; $display("FAIL store_RspValid_E1 got=%b exp=0", ifa.RspValid); end
    @(posedge Clk);
    #1;
    checks++; if (ifa.RspValid !== 1'b1 || ifa.RspErr !== 1'b0 || ifa.RspRData !== 24'h0) begin
      errors++; $display("FAIL store_rsp_E2 valid=%b err=%b rdata=%h exp 1/0/000000", ifa.RspValid, ifa.RspErr, ifa.RspRData);
    end
    checks++; if (mem_a[5] !== 24'hABCDEF) begin errors++; $display("FAIL store_mem5 got=%h exp=abcdef", mem_a[5]); end
    @(posedge Clk);
    #1;
    checks++; if (ifa.RspValid !== 1'b0 || ifa.ReqReady !== 1'b1) begin
      errors++; $display("FAIL store_handshake valid=%b ready=%b exp 0/1", ifa.RspValid, ifa.ReqReady);
    end
    issue(0, 1'b0, 24'd5, 24'h0);
    wait_rsp(0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL load_latency got=%0d exp=2", cyc); end
    checks++; if (ifa.RspRData !== 24'hABCDEF || ifa.RspErr !== 1'b0) begin
      errors++; $display("FAIL load_data rdata=%h err=%b exp abcdef/0", ifa.RspRData, ifa.RspErr);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_out_of_range;
    int cyc;
    issue(0, 1'b1, 24'd24, 24'h123456);
    checks++; if (ifa.MemWrite !== 1'b0) begin errors++; $display("FAIL oor_MemWrite got=%b exp=0", ifa.MemWrite); end
    checks++; if (ifa.MemAddress !== 24'd5) begin errors++; $display("FAIL oor_MemAddress_kept got=%h exp=5", ifa.MemAddress); end
    checks++; if (ifa.RspValid !== 1'b1 || ifa.RspErr !== 1'b1 || ifa.RspRData !== 24'h0) begin
      errors++; $display("FAIL oor_rsp_E1 valid=%b err=%b rdata=%h exp 1/1/000000", ifa.RspValid, ifa.RspErr, ifa.RspRData);
    end
    @(posedge Clk);
    #1;
    issue(0, 1'b0, 24'hFF0003, 24'h0);
    checks++; if (ifa.RspErr !== 1'b1 || ifa.MemWrite !== 1'b0) begin
      errors++; $display("FAIL oor_high_bits err=%b memwrite=%b exp 1/0", ifa.RspErr, ifa.MemWrite);
    end
    @(posedge Clk);
    #1;
    issue(0, 1'b0, 24'd23, 24'h0);
    wait_rsp(0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL last_addr_latency got=%0d exp=2", cyc); end
    checks++; if (ifa.RspErr !== 1'b0 || ifa.RspRData !== 24'hA00017) begin
      errors++; $display("FAIL last_addr_rsp err=%b rdata=%h exp 0/a00017", ifa.RspErr, ifa.RspRData);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    ifa.RspReady = 1'b0;
    issue(0, 1'b0, 24'd2, 24'h0);
    wait_rsp(0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", cyc); end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        ifa.ReqValid = 1'b1; ifa.ReqWrite = 1'b1; ifa.ReqAddr = 24'd3; ifa.ReqWData = 24'h777777;
      end
      @(posedge Clk);
      #1;
      ifa.ReqValid = 1'b0;
      checks++; if (ifa.RspValid !== 1'b1 || ifa.RspRData !== 24'hA00002 || ifa.ReqReady !== 1'b0 || ifa.MemWrite !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b rdata=%h ready=%b memwrite=%b exp 1/a00002/0/0",
                           i, ifa.RspValid, ifa.RspRData, ifa.ReqReady, ifa.MemWrite);
      end
    end
    ifa.RspReady = 1'b1;
    @(posedge Clk);
    #1;
    checks++; if (ifa.RspValid !== 1'b0 || ifa.ReqReady !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b exp 0/1", ifa.RspValid, ifa.ReqReady);
    end
    checks++; if (mem_a[3] !== 24'hA00003 || ifa.MemAddress !== 24'd2) begin
      errors++; $display("FAIL bp_ignored_req mem3=%h addr=%h exp a00003/2", mem_a[3], ifa.MemAddress);
    end
  endtask

  task automatic test_latency_sweep;
    int cyc;
    issue(1, 1'b0, 24'd4, 24'h0);
    wait_rsp(1, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL w0_latency got=%0d exp=1", cyc); end
    checks++; if (ifb.RspRData !== 24'h5A5A5E) begin errors++; $display("FAIL w0_rdata got=%h exp=5a5a5e", ifb.RspRData); end
    issue(2, 1'b0, 24'd9, 24'h0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (ifc.MemAddress !== 24'd9 || ifc.RspValid !== 1'b0) begin
        errors++; $display("FAIL w3_access[%0d] addr=%h valid=%b exp 9/0", k, ifc.MemAddress, ifc.RspValid);
      end
      @(posedge Clk);
      #1;
    end
    checks++; if (ifc.RspValid !== 1'b1 || ifc.RspRData !== 24'h5A5A53) begin
      errors++; $display("FAIL w3_rsp_E4 valid=%b rdata=%h exp 1/5a5a53", ifc.RspValid, ifc.RspRData);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_in_flight;
    issue(0, 1'b1, 24'd7, 24'h00FF00);
    checks++; if (ifa.MemWrite !== 1'b1) begin errors++; $display("FAIL rif_MemWrite_E0 got=%b exp=1", ifa.MemWrite); end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++; if (ifa.MemWrite !== 1'b0) begin errors++; $display("FAIL rif_MemWrite_async got=%b exp=0", ifa.MemWrite); end
    checks++; if (ifa.ReqReady !== 1'b1 || ifa.RspValid !== 1'b0) begin
      errors++; $display("FAIL rif_idle ready=%b valid=%b exp 1/0", ifa.ReqReady, ifa.RspValid);
    end
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++; if (mem_a[7] !== 24'hA00007) begin errors++; $display("FAIL rif_mem7 got=%h exp=a00007", mem_a[7]); end
    checks++; if (ifa.RspValid !== 1'b0 || ifa.ReqReady !== 1'b1 || ifa.MemWrite !== 1'b0) begin
      errors++; $display("FAIL rif_after valid=%b ready=%b memwrite=%b exp 0/1/0", ifa.RspValid, ifa.ReqReady, ifa.MemWrite);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Rst_n  = 1'b0;
    ifa.ReqValid = 1'b0; ifa.ReqWrite = 1'b0; ifa.ReqAddr = '0; ifa.ReqWData = '0; ifa.RspReady = 1'b1;
    ifb.ReqValid = 1'b0; ifb.ReqWrite = 1'b0; ifb.ReqAddr = '0; ifb.ReqWData = '0; ifb.RspReady = 1'b1;
    ifc.ReqValid = 1'b0; ifc.ReqWrite = 1'b0; ifc.ReqAddr = '0; ifc.ReqWData = '0; ifc.RspReady = 1'b1;

    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_latency_sweep();
    test_reset_in_flight();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dmem_access_ctrl
